// File: rtl/gent_policy_rand_gen.sv
// ---------------------------------------------------------------------------
// gent_policy_rand_gen
//
// Constrained-random value source. Candidates are drawn from a 32-bit Galois
// LFSR, masked for alignment, and rejection-sampled against a latched policy
// (inclusive [min,max] range plus an optional single excluded value).
// Accepted values are offered on a valid/ready stream. After MAX_TRIES
// consecutive rejections, cfg_min is emitted with out_fallback set.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   cfg_load       latch cfg_* fields (honoured only in IDLE)
//   cfg_min        inclusive lower bound (unsigned)
//   cfg_max        inclusive upper bound (unsigned)
//   cfg_align_mask candidate bits forced to 0
//   cfg_excl_en    enable single-value exclusion
//   cfg_excl_val   excluded value
//   gen_en         level enable for generation
//   cfg_err        latched policy has min > max
//   out_valid      out_data holds a value
//   out_ready      consumer accepts the value
//   out_data       generated value
//   out_fallback   out_data is the fallback, not a sampled value
// ---------------------------------------------------------------------------
module gent_policy_rand_gen #(
   parameter int unsigned WIDTH     = 16,
   parameter logic [31:0] SEED      = 32'hACE1_0001,
   parameter int unsigned MAX_TRIES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_load,
   input  logic [WIDTH-1:0] cfg_min,
   input  logic [WIDTH-1:0] cfg_max,
   input  logic [WIDTH-1:0] cfg_align_mask,
   input  logic             cfg_excl_en,
   input  logic [WIDTH-1:0] cfg_excl_val,
   input  logic             gen_en,
   output logic             cfg_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_fallback
);

   localparam int unsigned   TW       = $clog2(MAX_TRIES) + 1;
   localparam logic [31:0]   SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [31:0]   FB_MASK  = 32'h8020_0003;
   localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAW,
      ST_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      lfsr_q, lfsr_d, lfsr_step;
   logic [TW-1:0]    tries_q, tries_d;

   logic [WIDTH-1:0] min_q, max_q, mask_q, excl_val_q;
   logic             excl_en_q;
   logic             load_en;

   logic [WIDTH-1:0] cand;
   logic             accept;

   logic             cfg_err_d;
   logic             valid_d;
   logic [WIDTH-1:0] data_d;
   logic             fb_d;

   // Candidate and acceptance are evaluated on the pre-advance LFSR value.
   always_comb begin
      cand      = lfsr_q[WIDTH-1:0] & ~mask_q;
      accept    = (cand >= min_q) && (cand <= max_q) &&
                  !(excl_en_q && (cand == excl_val_q));
      lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? FB_MASK : 32'd0);
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      tries_d = tries_q;
      data_d  = out_data;
      fb_d    = out_fallback;
      load_en = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_load) begin
               load_en = 1'b1;
            end else if (gen_en && !cfg_err) begin
               state_d = ST_DRAW;
            end
         end

         ST_DRAW: begin
            lfsr_d = lfsr_step;
            if (!gen_en) begin
               state_d = ST_IDLE;
               tries_d = '0;
            end else if (accept) begin
               state_d = ST_HOLD;
               data_d  = cand;
               fb_d    = 1'b0;
               tries_d = '0;
            end else if (tries_q == LAST_TRY) begin
               state_d = ST_HOLD;
               data_d  = min_q;
               fb_d    = 1'b1;
               tries_d = '0;
            end else begin
               tries_d = tries_q + TW'(1);
            end
         end

         ST_HOLD: begin
            // out_valid is high throughout HOLD, so out_ready alone completes
            // the handshake.
            if (out_ready) begin
               state_d = gen_en ? ST_DRAW : ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            tries_d = '0;
         end
      endcase

      valid_d   = (state_d == ST_HOLD);
      cfg_err_d = load_en ? (cfg_min > cfg_max) : cfg_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         lfsr_q       <= SEED_EFF;
         tries_q      <= '0;
         min_q        <= '0;
         max_q        <= '0;
         mask_q       <= '0;
         excl_en_q    <= 1'b0;
         excl_val_q   <= '0;
         cfg_err      <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_fallback <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         tries_q      <= tries_d;
         cfg_err      <= cfg_err_d;
         out_valid    <= valid_d;
         out_data     <= data_d;
         out_fallback <= fb_d;
         if (load_en) begin
            min_q      <= cfg_min;
            max_q      <= cfg_max;
            mask_q     <= cfg_align_mask;
            excl_en_q  <= cfg_excl_en;
            excl_val_q <= cfg_excl_val;
         end
      end
   end

endmodule

// File: tb/tb_gent_policy_rand_gen.sv
// ---------------------------------------------------------------------------
// tb_gent_policy_rand_gen
//
// Directed self-checking bench for gent_policy_rand_gen (WIDTH=16,
// MAX_TRIES=8). Inputs are driven and outputs sampled on the falling edge.
// A transaction-level policy model predicts each emitted value, its
// fallback flag and the number of cycles until it appears.
// ---------------------------------------------------------------------------
module tb_gent_policy_rand_gen;

   localparam int unsigned W    = 16;
   localparam int unsigned MT   = 8;
   localparam logic [31:0] SEED = 32'hACE1_0001;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_load;
   logic [W-1:0]  cfg_min, cfg_max, cfg_align_mask, cfg_excl_val;
   logic          cfg_excl_en;
   logic          gen_en;
   logic          cfg_err;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_fallback;

   int checks = 0;
   int errors = 0;

   // model state
   logic [31:0]   m_lfsr;
   logic [W-1:0]  p_min, p_max, p_mask, p_val;
   logic          p_en;

   always #5 clk = ~clk;

   gent_policy_rand_gen #(
      .WIDTH    (W),
      .SEED     (SEED),
      .MAX_TRIES(MT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_load      (cfg_load),
      .cfg_min       (cfg_min),
      .cfg_max       (cfg_max),
      .cfg_align_mask(cfg_align_mask),
      .cfg_excl_en   (cfg_excl_en),
      .cfg_excl_val  (cfg_excl_val),
      .gen_en        (gen_en),
      .cfg_err       (cfg_err),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_fallback  (out_fallback)
   );

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      logic [31:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 32'h8020_0003;
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      cfg_load       = 1'b0;
      cfg_min        = '0;
      cfg_max        = '0;
      cfg_align_mask = '0;
      cfg_excl_en    = 1'b0;
      cfg_excl_val   = '0;
      gen_en         = 1'b0;
      out_ready      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      m_lfsr = SEED;
      p_min  = '0;
      p_max  = '0;
      p_mask = '0;
      p_en   = 1'b0;
      p_val  = '0;
   endtask

   // Called on a falling edge with the DUT in IDLE; returns on the falling
   // edge where the new policy (and cfg_err) is visible.
   task automatic load_cfg(input logic [W-1:0] mn, input logic [W-1:0] mx,
                           input logic [W-1:0] mk, input logic en,
                           input logic [W-1:0] v);
      cfg_min        = mn;
      cfg_max        = mx;
      cfg_align_mask = mk;
      cfg_excl_en    = en;
      cfg_excl_val   = v;
      cfg_load       = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      p_min  = mn;
      p_max  = mx;
      p_mask = mk;
      p_en   = en;
      p_val  = v;
   endtask

   // Called on the falling edge where generation is (re)started: either
   // gen_en was just raised in IDLE or a handshake is pending. adj shortens
   // the expected latency when called one cycle later than that.
   task automatic next_value(input string name, input int adj,
                             output logic [W-1:0] d, output logic f);
      logic [W-1:0] cand, e_data;
      logic         e_fb, found;
      int           k, n;
      k = 0;
      found = 1'b0;
      e_data = p_min;
      e_fb = 1'b1;
      for (int i = 0; i < MT; i++) begin
         cand   = m_lfsr[W-1:0] & ~p_mask;
         m_lfsr = lfsr_next(m_lfsr);
         k++;
         if (cand >= p_min && cand <= p_max && !(p_en && cand == p_val)) begin
            e_data = cand;
            e_fb   = 1'b0;
            found  = 1'b1;
            break;
         end
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      d = out_data;
      f = out_fallback;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, n);
      end
      checks++;
      if (out_data !== e_data) begin
         errors++;
         $display("FAIL %s data: got %h, required %h", name, out_data, e_data);
      end
      checks++;
      if (out_fallback !== e_fb) begin
         errors++;
         $display("FAIL %s fallback: got %b, required %b", name, out_fallback, e_fb);
      end
      checks++;
      if (n != k + 1 - adj) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, required %0d", name, n, k + 1 - adj);
      end
   endtask

   // Called on the falling edge where out_valid=1 and out_ready=1.
   task automatic stop_gen();
      gen_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL reset out_data: got %h, required 0000", out_data); end
      checks++;
      if (out_fallback !== 1'b0) begin errors++; $display("FAIL reset out_fallback: got %b, required 0", out_fallback); end
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset cfg_err: got %b, required 0", cfg_err); end
   endtask

   task automatic test_first_values();
      logic [W-1:0] exp_v [4];
      logic [W-1:0] d;
      logic         f;
      exp_v = '{16'h0001, 16'h8003, 16'h4002, 16'h2001};
      load_cfg(16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000);
      gen_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         next_value("first", 0, d, f);
         checks++;
         if (d !== exp_v[i]) begin
            errors++;
            $display("FAIL first seq[%0d]: got %h, required %h", i, d, exp_v[i]);
         end
      end
      stop_gen();
   endtask

   task automatic test_point_range();
      logic [W-1:0] d;
      logic         f;
      load_cfg(16'h0005, 16'h0005, 16'h0000, 1'b0, 16'h0000);
      gen_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         next_value("point", 0, d, f);
         checks++;
         if (d !== 16'h0005) begin
            errors++;
            $display("FAIL point value[%0d]: got %h, required 0005", i, d);
         end
      end
      stop_gen();
   endtask

   task automatic test_exclusion();
      logic [W-1:0] d;
      logic         f;
      // mask 0xFFFA leaves candidates in {0,1,4,5}; only 5 is acceptable
      load_cfg(16'h0004, 16'h0005, 16'hFFFA, 1'b1, 16'h0004);
      gen_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         next_value("excl", 0, d, f);
         checks++;
         if (d !== (f ? 16'h0004 : 16'h0005)) begin
            errors++;
            $display("FAIL excl value[%0d]: got %h fb=%b, required %h", i, d, f, f ? 16'h0004 : 16'h0005);
         end
      end
      stop_gen();
   endtask

   task automatic test_impossible();
      logic [W-1:0] d;
      logic         f;
      load_cfg(16'h0006, 16'h0006, 16'h0000, 1'b1, 16'h0006);
      gen_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         next_value("impossible", 0, d, f);
         checks++;
         if (d !== 16'h0006 || f !== 1'b1) begin
            errors++;
            $display("FAIL impossible[%0d]: got %h fb=%b, required 0006 fb=1", i, d, f);
         end
      end
      stop_gen();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] d, held;
      logic         f;
      load_cfg(16'h0000, 16'hFFFF, 16'h0003, 1'b0, 16'h0000);
      out_ready = 1'b0;
      gen_en    = 1'b1;
      next_value("bp_first", 0, held, f);
      checks++;
      if (held[1:0] !== 2'b00) begin
         errors++;
         $display("FAIL bp align: got %h, required low bits 00", held);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== held) begin
            errors++;
            $display("FAIL bp stall[%0d]: valid=%b data=%h, required valid=1 data=%h", i, out_valid, out_data, held);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp drop: out_valid=%b, required 0", out_valid);
      end
      next_value("bp_after", 1, d, f);
      checks++;
      if (d[1:0] !== 2'b00) begin
         errors++;
         $display("FAIL bp align2: got %h, required low bits 00", d);
      end
      stop_gen();
   endtask

   task automatic test_cfg_err();
      logic [W-1:0] d, held;
      logic         f;
      load_cfg(16'd10, 16'd3, 16'h0000, 1'b0, 16'h0000);
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfgerr set: got %b, required 1", cfg_err); end
      gen_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cfgerr blocked[%0d]: out_valid=%b, required 0", i, out_valid);
         end
      end
      gen_en = 1'b0;
      load_cfg(16'd3, 16'd10, 16'hFFF0, 1'b0, 16'h0000);
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfgerr clear: got %b, required 0", cfg_err); end
      gen_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         next_value("cfg_ok", 0, d, f);
         checks++;
         if (f ? (d !== 16'd3) : (d < 16'd3 || d > 16'd10)) begin
            errors++;
            $display("FAIL cfg_ok range[%0d]: got %h fb=%b, required in [3,10]", i, d, f);
         end
      end
      // stall in HOLD and attempt a (bad) reconfiguration
      out_ready = 1'b0;
      held = d;
      cfg_min  = 16'd20;
      cfg_max  = 16'd1;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
         errors++;
         $display("FAIL hold load ignored: err=%b valid=%b data=%h, required err=0 valid=1 data=%h",
                  cfg_err, out_valid, out_data, held);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_value("cfg_keep", 0, d, f);
         checks++;
         if (f ? (d !== 16'd3) : (d < 16'd3 || d > 16'd10)) begin
            errors++;
            $display("FAIL cfg_keep range[%0d]: got %h fb=%b, required in [3,10]", i, d, f);
         end
      end
      stop_gen();
   endtask

   task automatic test_reset_hold();
      logic [W-1:0] d;
      logic         f;
      do_reset();
      load_cfg(16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000);
      out_ready = 1'b0;
      gen_en    = 1'b1;
      next_value("rst_pre", 0, d, f);
      checks++;
      if (d !== 16'h0001) begin errors++; $display("FAIL rst_pre value: got %h, required 0001", d); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_fallback !== 1'b0) begin
         errors++;
         $display("FAIL async reset: valid=%b data=%h fb=%b, required 0 0000 0", out_valid, out_data, out_fallback);
      end
      gen_en    = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rst_n  = 1'b1;
      m_lfsr = SEED;
      load_cfg(16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000);
      gen_en = 1'b1;
      next_value("rst_post0", 0, d, f);
      checks++;
      if (d !== 16'h0001) begin errors++; $display("FAIL rst_post seq0: got %h, required 0001", d); end
      next_value("rst_post1", 0, d, f);
      checks++;
      if (d !== 16'h8003) begin errors++; $display("FAIL rst_post seq1: got %h, required 8003", d); end
      stop_gen();
   endtask

   initial begin
      test_reset();
      test_first_values();
      test_point_range();
      test_exclusion();
      test_impossible();
      test_backpressure();
      test_cfg_err();
      test_reset_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
